// File: rtl/alarm_pkg.sv
// Shared state encodings and default timing constants for the alarm subsystem
// (controller, keypad decoder and LED driver).
package alarm_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_ARMING = 3'd1;
  localparam logic [STATE_W-1:0] ST_ARMED  = 3'd2;
  localparam logic [STATE_W-1:0] ST_ENTRY  = 3'd3;
  localparam logic [STATE_W-1:0] ST_ALARM  = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = ST_IDLE,
    S_ARMING = ST_ARMING,
    S_ARMED  = ST_ARMED,
    S_ENTRY  = ST_ENTRY,
    S_ALARM  = ST_ALARM
  } state_e;

  localparam int DEF_HALF_S_TICKS   = 25_000_000;
  localparam int DEF_ARM_DELAY_HS   = 20;
  localparam int DEF_ENTRY_DELAY_HS = 30;
  localparam int DEF_ALARM_HS       = 120;

  // States that run the half-second timebase and blink the generator.
  function automatic logic is_timed(state_e s);
    return (s == S_ARMING) || (s == S_ENTRY) || (s == S_ALARM);
  endfunction

endpackage

// File: rtl/half_second_ticker.sv
// Half-second prescaler: counts 0..HALF_S_TICKS-1 while enabled and flags the
// last count with a one-cycle tick. A clear restarts the interval.
module half_second_ticker
  import alarm_pkg::*;
#(
  parameter int HALF_S_TICKS = DEF_HALF_S_TICKS
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int PRESC_W = $clog2(HALF_S_TICKS);
  localparam logic [PRESC_W-1:0] LAST = PRESC_W'(HALF_S_TICKS - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;

  always_comb begin
    presc_d = presc_q;
    if (clr_i) begin
      presc_d = '0;
    end else if (en_i) begin
      presc_d = (presc_q == LAST) ? '0 : presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) presc_q <= '0;
    else       presc_q <= presc_d;
  end

  // A tick coinciding with a state change belongs to the old state; drop it.
  assign tick_o = en_i && !clr_i && (presc_q == LAST);

endmodule

// File: rtl/alarm_controller.sv
// Arm/entry/alarm sequencer for the siren generator; owns the shared
// half-second timebase and drives the status outputs, all registered.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int HALF_S_TICKS   = DEF_HALF_S_TICKS,
  parameter int ARM_DELAY_HS   = DEF_ARM_DELAY_HS,
  parameter int ENTRY_DELAY_HS = DEF_ENTRY_DELAY_HS,
  parameter int ALARM_HS       = DEF_ALARM_HS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               arm,
  input  logic               code_ok,
  input  logic               door_sensor,
  output logic               enable_siren,
  output logic               two_hz_enable,
  output logic               armed_led,
  output logic [STATE_W-1:0] state
);

  localparam int MAX_AE = (ARM_DELAY_HS > ENTRY_DELAY_HS) ? ARM_DELAY_HS : ENTRY_DELAY_HS;
  localparam int MAX_HS = (MAX_AE > ALARM_HS) ? MAX_AE : ALARM_HS;
  localparam int HS_W   = $clog2(MAX_HS + 1);

  state_e          state_q, state_d;
  logic [HS_W-1:0] hs_cnt_q, hs_cnt_d;
  logic [1:0]      sync_q;
  logic            door_s;
  logic            tick;
  logic            state_chg;
  logic            siren_q, hz_q, led_q;

  assign door_s = sync_q[1];

  half_second_ticker #(
    .HALF_S_TICKS(HALF_S_TICKS)
  ) u_ticker (
    .clk_i  (clock),
    .rst_i  (reset),
    .clr_i  (state_chg),
    .en_i   (is_timed(state_q)),
    .tick_o (tick)
  );

  // Disarm wins over every other transition, including a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    if (code_ok && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (arm && !code_ok)                      state_d = S_ARMING;
        S_ARMING: if (hs_cnt_q == HS_W'(ARM_DELAY_HS))      state_d = S_ARMED;
        S_ARMED:  if (door_s)                               state_d = S_ENTRY;
        S_ENTRY:  if (hs_cnt_q == HS_W'(ENTRY_DELAY_HS))    state_d = S_ALARM;
        S_ALARM:  if (hs_cnt_q == HS_W'(ALARM_HS))          state_d = S_ARMED;
        default:                                            state_d = S_IDLE;
      endcase
    end
    state_chg = (state_d != state_q);
    hs_cnt_d  = hs_cnt_q;
    if (state_chg)  hs_cnt_d = '0;
    else if (tick)  hs_cnt_d = hs_cnt_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      hs_cnt_q <= '0;
      sync_q   <= '0;
      siren_q  <= 1'b0;
      hz_q     <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hs_cnt_q <= hs_cnt_d;
      sync_q   <= {sync_q[0], door_sensor};
      siren_q  <= (state_d == S_ALARM);
      hz_q     <= tick;
      led_q    <= (state_d == S_ARMED) || (state_d == S_ENTRY) || (state_d == S_ALARM);
    end
  end

  assign state         = state_q;
  assign enable_siren  = siren_q;
  assign two_hz_enable = hz_q;
  assign armed_led     = led_q;

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Sequencing controller for the siren generator. It runs the arm/entry/alarm state machine from keypad and sensor events and drives the generator's `eneble_siren` and `two_hz_enable` inputs. It owns the half-second timebase, so the generator's color toggle and the controller's delays share one prescaler. It sits between the keypad decoder and `gerador_sirene`, and it also drives the status LEDs.

## Interface
Parameters:
- `HALF_S_TICKS`, default 25_000_000: clock cycles per half second. Minimum 2.
- `ARM_DELAY_HS`, default 20: exit delay in half seconds. Minimum 1.
- `ENTRY_DELAY_HS`, default 30: entry delay in half seconds. Minimum 1.
- `ALARM_HS`, default 120: siren duration in half seconds before automatic re-arm. Minimum 1.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `arm`  in  1  one-cycle pulse from keypad, synchronous to `clock`.
- `code_ok`  in  1  one-cycle pulse on a valid disarm code, synchronous to `clock`.
- `door_sensor`  in  1  asynchronous level; 1 = door open.
- `enable_siren`  out  1  to generator `eneble_siren`; high only in ALARM.
- `two_hz_enable`  out  1  one-cycle half-second pulse to the generator.
- `armed_led`  out  1  high in ARMED, ENTRY and ALARM.
- `state`  out  3  current state encoding, for debug and LEDs.

## Operation
- `door_sensor` passes through a 2-FF synchronizer, giving `door_s`. Latency is 2 cycles.
- States and encodings: IDLE=0, ARMING=1, ARMED=2, ENTRY=3, ALARM=4.
- IDLE: `arm` → ARMING.
- ARMING: `ARM_DELAY_HS` half-second ticks elapse → ARMED. The door state is ignored during the exit delay.
- ARMED: `door_s`=1 → ENTRY.
- ENTRY: `ENTRY_DELAY_HS` ticks elapse → ALARM.
- ALARM: `ALARM_HS` ticks elapse → ARMED. If the door is still open, this leads to ENTRY on the next cycle.
- `code_ok` in any non-IDLE state → IDLE. This has priority over every other transition, including a timeout in the same cycle.
- `arm` outside IDLE is ignored. `code_ok` in IDLE is ignored.
- Simultaneous `arm` and `code_ok` in IDLE → stay in IDLE.
- Timebase:
  - Prescaler counts 0..`HALF_S_TICKS`-1.
  - A half-second counter `hs_cnt` counts elapsed ticks.
  - Both clear on every state change, so every timed state starts a fresh interval.
- Blink windows: `two_hz_enable` pulses only in ARMING, ENTRY and ALARM. It is held 0 in IDLE and ARMED.
- Width rules:
  - Prescaler width is $clog2(`HALF_S_TICKS`).
  - `hs_cnt` width is $clog2(max delay + 1).
  - Neither counter may wrap within a state: the timeout fires at equality, never at overflow.

## Timing
- Reset values: state=IDLE, prescaler=0, `hs_cnt`=0, synchronizer=0. All outputs are 0.
- Reset mid-operation takes effect immediately and asynchronously. This includes dropping `enable_siren` in ALARM.
- All outputs are registered.
- Pulse timing: let cycle 0 be the first cycle `state` shows a timed state. `two_hz_enable` is high for exactly one cycle at cycles k·`HALF_S_TICKS` for k ≥ 1.
- Timeout timing: on the k=DELAY pulse cycle, `state` shows the next state in the following cycle. The pulse on the final tick is still emitted.
- Example: ARMING with `ARM_DELAY_HS`=2 and `HALF_S_TICKS`=4. Pulses occur at cycles 4 and 8; `state`=ARMED at cycle 9.
- `arm`/`code_ok` → `state` change: 1 cycle.
- `door_sensor` rising edge → ENTRY visible on `state`: 3 cycles, with no other events.
- `enable_siren` rises in the same cycle `state`=ALARM.

## Structure
- Shared package/include `alarm_pkg` holds:
  - state encodings as localparams;
  - `STATE_W`=3;
  - default timing constants, reused by the keypad and LED blocks.
- One sub-module, `half_second_ticker`:
  - inputs: prescaler with clear and enable;
  - output: a one-cycle tick;
  - parameter: `HALF_S_TICKS`.
- The FSM, `hs_cnt` and synchronizer stay in `alarm_controller`.

## Test plan
All scenarios use `HALF_S_TICKS`=4, `ARM_DELAY_HS`=2, `ENTRY_DELAY_HS`=3, `ALARM_HS`=4.
- Arm cycle: `arm` pulse at t=0 → `state`=1 at t=1. Pulses at t=5 and t=9. `state`=2 at t=10; `armed_led`=1.
- Intrusion: in ARMED, raise `door_sensor` at t=0 → `state`=3 at t=3. Three pulses follow, then `state`=4 and `enable_siren`=1 until 4 more pulses. Then `state`=2; with the door still open, `state`=3 one cycle later.
- Disarm priority: assert `code_ok` on the final ENTRY tick cycle → `state`=0, ALARM is never entered, and `enable_siren` stays 0.
- Simultaneous `arm`+`code_ok` in IDLE → `state` remains 0. `arm` during ARMING has no effect on the timing of the pulses.
- Async reset during ALARM, mid-prescaler → all outputs are 0 within the same cycle. After release, an `arm` pulse gives the first `two_hz_enable` exactly 4 cycles after ARMING entry.
- Door glitch: a 1-cycle `door_sensor` pulse is still caught by the synchronizer and → ENTRY, checking that the latency is 3 cycles.
